// File: rtl/fp16_pkg.sv
// Shared constants, state encoding and packing helper for the fp16 adder back-end.
// The mantissa layout is {carry, hidden, frac[9:0], guard, round}.
package fp16_pkg;

    localparam logic [4:0] FP16_EXP_MAX   = 5'h1F;
    localparam logic [9:0] FP16_QNAN_FRAC = 10'h200;
    localparam int         FP16_BIAS      = 15;

    // Bit positions inside the 14-bit post-add mantissa
    localparam int BIT_CARRY  = 13;
    localparam int BIT_HIDDEN = 12;
    localparam int BIT_GUARD  = 1;
    localparam int BIT_ROUND  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [15:0] pack_half(input logic       sign,
                                              input logic [4:0] exp_field,
                                              input logic [9:0] frac);
        return {sign, exp_field, frac};
    endfunction

endpackage

// File: rtl/fp16_round_rne.sv
// Combinational round-to-nearest-even on a normalised (or denormal) mantissa,
// with exponent bump on significand carry, overflow saturation and packing.
module fp16_round_rne
    import fp16_pkg::*;
(
    input  logic        sign,
    input  logic [5:0]  exp_in,
    input  logic [12:0] mant,
    input  logic        sticky,
    output logic [15:0] result,
    output logic        overflow
);

    function automatic logic rne_round_up(input logic guard,
                                          input logic rnd,
                                          input logic stk,
                                          input logic lsb);
        return guard & (rnd | stk | lsb);
    endfunction

    logic        round_up;
    logic [11:0] sig_sum;
    logic        hidden_rnd;
    logic [9:0]  frac_rnd;
    logic [5:0]  exp_rnd;
    logic [4:0]  exp_field;

    always_comb begin
        round_up   = rne_round_up(mant[BIT_GUARD], mant[BIT_ROUND], sticky, mant[BIT_GUARD+1]);
        sig_sum    = {1'b0, mant[BIT_HIDDEN:BIT_GUARD+1]} + {11'd0, round_up};
        // A carry out of {hidden, frac} renormalises to 1.0 x 2^(exp+1)
        hidden_rnd = sig_sum[11] | sig_sum[10];
        frac_rnd   = sig_sum[11] ? 10'd0 : sig_sum[9:0];
        exp_rnd    = exp_in + {5'd0, sig_sum[11]};
        // Denormals report exponent field 0; one that rounds up into the hidden bit becomes exp 1
        exp_field  = hidden_rnd ? exp_rnd[4:0] : 5'd0;
        overflow   = (exp_in >= 6'd31) || (exp_rnd >= 6'd31);
        if (overflow) begin
            result = pack_half(sign, FP16_EXP_MAX, 10'd0);
        end else begin
            result = pack_half(sign, exp_field, frac_rnd);
        end
    end

endmodule

// File: rtl/fp16_normalize_round.sv
// fp16 adder back-end: normalises the post-add mantissa one bit per cycle, then
// rounds RNE and packs a binary16 result behind a valid/ready handshake.
module fp16_normalize_round
    import fp16_pkg::*;
#(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10
)
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic                  IN_SIGN,
    input  logic [EXP_W-1:0]      IN_EXP_HALF,
    input  logic [FRAC_W+3:0]     IN_MANT_HALF,
    input  logic                  IN_STICKY_BIT,
    input  logic                  IN_EXCEPTION_HALF,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [EXP_W+FRAC_W:0] OUT_RESULT_HALF,
    output logic                  OUT_OVERFLOW,
    output logic                  OUT_EXCEPTION_HALF
);

    state_e      state_q, state_d;
    logic        sign_q, sign_d;
    logic [5:0]  exp_q, exp_d;
    logic [12:0] mant_q, mant_d;
    logic        sticky_q, sticky_d;
    logic [15:0] result_q, result_d;
    logic        overflow_q, overflow_d;
    logic        exception_q, exception_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;

    logic [15:0] rnd_result;
    logic        rnd_overflow;

    fp16_round_rne u_round (
        .sign     (sign_q),
        .exp_in   (exp_q),
        .mant     (mant_q),
        .sticky   (sticky_q),
        .result   (rnd_result),
        .overflow (rnd_overflow)
    );

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        sticky_d    = sticky_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        exception_d = exception_q;

        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    sign_d      = IN_SIGN;
                    exp_d       = {1'b0, IN_EXP_HALF};
                    mant_d      = IN_MANT_HALF[BIT_HIDDEN:0];
                    sticky_d    = IN_STICKY_BIT;
                    result_d    = 16'd0;
                    overflow_d  = 1'b0;
                    exception_d = 1'b0;
                    if (IN_EXCEPTION_HALF) begin
                        result_d    = pack_half(IN_SIGN, FP16_EXP_MAX, FP16_QNAN_FRAC);
                        exception_d = 1'b1;
                        state_d     = DONE;
                    end else if (IN_MANT_HALF == 14'd0 && !IN_STICKY_BIT) begin
                        result_d = pack_half(IN_SIGN, 5'd0, 10'd0);
                        state_d  = DONE;
                    end else if (IN_MANT_HALF[BIT_CARRY]) begin
                        // Carry: one right shift, the old round bit folds into sticky
                        mant_d   = IN_MANT_HALF[BIT_CARRY:1];
                        sticky_d = IN_STICKY_BIT | IN_MANT_HALF[BIT_ROUND];
                        exp_d    = {1'b0, IN_EXP_HALF} + 6'd1;
                        state_d  = ROUND;
                    end else if (IN_MANT_HALF[BIT_HIDDEN] || IN_EXP_HALF <= 5'd1) begin
                        state_d = ROUND;
                    end else begin
                        state_d = NORM;
                    end
                end
            end

            NORM: begin
                // Leave as soon as the shifted value is normalised or has reached the denormal exponent
                if (exp_q <= 6'd1) begin
                    state_d = ROUND;
                end else begin
                    mant_d = {mant_q[BIT_HIDDEN-1:0], 1'b0};
                    exp_d  = exp_q - 6'd1;
                    if (mant_q[BIT_HIDDEN-1] || exp_q == 6'd2) begin
                        state_d = ROUND;
                    end
                end
            end

            ROUND: begin
                result_d   = rnd_result;
                overflow_d = rnd_overflow;
                state_d    = DONE;
            end

            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= 6'd0;
            mant_q      <= 13'd0;
            sticky_q    <= 1'b0;
            result_q    <= 16'd0;
            overflow_q  <= 1'b0;
            exception_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            sticky_q    <= sticky_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            exception_q <= exception_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign IN_READY           = in_ready_q;
    assign OUT_VALID          = out_valid_q;
    assign OUT_RESULT_HALF    = result_q;
    assign OUT_OVERFLOW       = overflow_q;
    assign OUT_EXCEPTION_HALF = exception_q;

endmodule

// File: doc/fp16_normalize_round.md
Name: fp16_normalize_round

Overview:
- Back-end of the fp16 adder datapath; the counterpart of the alignment stage.
- Takes the raw post-add mantissa sum, the common exponent, the sign and the sticky bit, and produces a packed IEEE-754 binary16 result.
- Normalises iteratively, one bit per cycle, then rounds to nearest, ties to even.
- Uses a valid/ready handshake on both sides so it can stall behind downstream logic.

Parameters:
- EXP_W, 5, exponent field width. Only the default is supported and verified.
- FRAC_W, 10, fraction field width. Only the default is supported and verified.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- IN_VALID  in  1  input operand valid.
- IN_READY  out  1  block can accept an operand; equals (state==IDLE).
- IN_SIGN  in  1  result sign.
- IN_EXP_HALF  in  5  common exponent; denormals arrive with exponent 1.
- IN_MANT_HALF  in  14  {carry, hidden, frac[9:0], guard, round}.
- IN_STICKY_BIT  in  1  OR of all bits lost below the round bit.
- IN_EXCEPTION_HALF  in  1  NaN/Inf flagged upstream.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  downstream accepts the result.
- OUT_RESULT_HALF  out  16  packed {sign, exp[4:0], frac[9:0]}.
- OUT_OVERFLOW  out  1  result saturated to Inf.
- OUT_EXCEPTION_HALF  out  1  passthrough of the exception flag.

Behaviour:
- Reset, asynchronous on RST_N low:
  - state=IDLE; all internal registers 0.
  - OUT_VALID=0, OUT_RESULT_HALF=0, OUT_OVERFLOW=0, OUT_EXCEPTION_HALF=0, IN_READY=1.
  - Reset asserted mid-operation abandons the operand with no output.
- States: IDLE, NORM, ROUND, DONE.
- IDLE, on IN_VALID (accept edge): latch all inputs, then branch in this priority order:
  - IN_EXCEPTION_HALF=1: result={IN_SIGN, 5'h1F, 10'h200}, OUT_EXCEPTION_HALF=1, go to DONE.
  - Mantissa==0 and sticky==0: result={IN_SIGN, 15'h0}, go to DONE.
  - carry=1: shift right 1 (round→sticky OR, guard→round, frac[0]→guard), exp+1, go to ROUND.
  - hidden=1 or exp==1: go to ROUND.
  - Otherwise: go to NORM.
- NORM, one cycle per step:
  - If hidden=1 or exp==1, go to ROUND.
  - Else shift the 14-bit mantissa left 1 (zero in, sticky unchanged), exp−1.
  - At most 11 cycles.
- ROUND (one cycle):
  - round_up = guard & (round | sticky | frac[0]).
  - Add round_up to {hidden, frac}. On carry-out: frac=0, hidden=1, exp+1.
  - exp field = 0 if hidden==0 (denormal), else exp. A denormal that rounds into the hidden bit yields exp field 1.
  - If exp ≥ 31 (before or after rounding): result={sign, 5'h1F, 10'h0}, OUT_OVERFLOW=1.
  - Go to DONE.
- DONE:
  - OUT_VALID=1; OUT_RESULT_HALF and flags held stable while OUT_READY=0.
  - On OUT_READY: go to IDLE, OUT_VALID=0 on the next cycle.
  - Flags are cleared on the next accept.
- Latency from the accept edge to OUT_VALID high:
  - exception/zero: 1 cycle.
  - carry or already normalised: 2 cycles.
  - n left shifts: 2+n cycles.
- No new operand is accepted until the result handshake completes (IN_READY=0 in NORM/ROUND/DONE); throughput is one operand in flight.
- Exponent arithmetic is done in 6 bits to detect overflow; underflow is impossible because NORM stops at exp==1.

Decomposition:
- Package fp16_pkg:
  - FP16_EXP_MAX=5'h1F, FP16_QNAN_FRAC=10'h200, FP16_BIAS=15.
  - State enum {IDLE, NORM, ROUND, DONE}.
  - Mantissa bit-index constants: CARRY=13, HIDDEN=12, GUARD=1, ROUND=0.
- Sub-module fp16_round_rne: combinational RNE increment, exponent bump, overflow detect and packing. Instantiated in the ROUND state path.

Test Plan:
- 1.0+1.0: IN_EXP=15, IN_MANT=14'b10_0000000000_00, sticky 0 → OUT_RESULT_HALF=16'h4000, OUT_VALID 2 cycles after accept.
- Cancellation: IN_EXP=15, IN_MANT=14'b00_0000000001_00 → 10 NORM cycles, result 16'h1400, latency 12.
- RNE ties: exp15, mant 01_0000000001_10, sticky 0 → 16'h3C02; mant 01_0000000000_10 → 16'h3C00; mant 01_0000000000_10, sticky 1 → 16'h3C01.
- Overflow: exp30, mant 01_1111111111_11 → 16'h7C00, OUT_OVERFLOW=1. Exception with IN_SIGN=1 → 16'hFE00, OUT_EXCEPTION_HALF=1, latency 1.
- Denormal: exp1, mant 00_0000000011_00 → no NORM cycles, result 16'h0003. Zero input with sign 0 → 16'h0000, latency 1.
- Backpressure and reset:
  - OUT_READY held low 5 cycles → OUT_VALID and result stable, IN_READY=0 throughout.
  - RST_N pulsed low mid-NORM → immediately IDLE, OUT_VALID=0, IN_READY=1, next operand processed correctly.
